riscv_mem_port_arbiter: RTL and testbench

//  Shares the single AXI-Lite master port to axil_ram between the core's instruction-fetch (IF) port and data-memory (DM) port.

---
 rtl/riscv_mem_arb_pkg.sv | 25 ++
 rtl/riscv_arb_rr2.sv | 25 ++
 rtl/riscv_mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_riscv_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the IF/DM memory-port arbiter: FSM states, owner encoding
// and the AXI OKAY response code.
package riscv_mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4,
        ACK     = 3'd5
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/riscv_arb_rr2.sv
// Two-input round-robin granter; bit 0 is IF, bit 1 is DM. With both requesting,
// the port that did not win last time is chosen.
module riscv_arb_rr2
    import riscv_mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_owner_t last_grant_i,
    output logic       gnt_valid_o,
    output arb_owner_t grant_o
);

    // Pick the winner from the request pattern and the previous grant
    always_comb begin
        grant_o = last_grant_i;
        case (req_i)
            2'b01:   grant_o = OWN_IF;
            2'b10:   grant_o = OWN_DM;
            2'b11:   grant_o = (last_grant_i == OWN_IF) ? OWN_DM : OWN_IF;
            default: grant_o = last_grant_i;
        endcase
    end

    assign gnt_valid_o = |req_i;

endmodule

// File: rtl/riscv_mem_port_arbiter.sv
// Serialises IF fetches and DM loads/stores onto one AXI-Lite master port,
// one transaction at a time, with a registered single-cycle ack per requester.
module riscv_mem_port_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 16,
    parameter  int DATA_WIDTH  = 64,
    parameter  int INSTR_WIDTH = 32,
    localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   aclk,
    input  logic                   anreset,
    input  logic                   i_if_req,
    input  logic [ADDR_WIDTH-1:0]  i_if_addr,
    output logic [INSTR_WIDTH-1:0] o_if_rdata,
    output logic                   o_if_ack,
    input  logic                   i_dm_req,
    input  logic                   i_dm_we,
    input  logic [ADDR_WIDTH-1:0]  i_dm_addr,
    input  logic [DATA_WIDTH-1:0]  i_dm_wdata,
    input  logic [STRB_WIDTH-1:0]  i_dm_wstrb,
    output logic [DATA_WIDTH-1:0]  o_dm_rdata,
    output logic                   o_dm_ack,
    output logic                   o_bus_err,
    output logic                   o_busy,
    output logic [ADDR_WIDTH-1:0]  m_axil_awaddr,
    output logic [2:0]             m_axil_awprot,
    output logic                   m_axil_awvalid,
    input  logic                   m_axil_awready,
    output logic [DATA_WIDTH-1:0]  m_axil_wdata,
    output logic [STRB_WIDTH-1:0]  m_axil_wstrb,
    output logic                   m_axil_wvalid,
    input  logic                   m_axil_wready,
    input  logic [1:0]             m_axil_bresp,
    input  logic                   m_axil_bvalid,
    output logic                   m_axil_bready,
    output logic [ADDR_WIDTH-1:0]  m_axil_araddr,
    output logic [2:0]             m_axil_arprot,
    output logic                   m_axil_arvalid,
    input  logic                   m_axil_arready,
    input  logic [DATA_WIDTH-1:0]  m_axil_rdata,
    input  logic [1:0]             m_axil_rresp,
    input  logic                   m_axil_rvalid,
    output logic                   m_axil_rready
);

    localparam int BEAT_OFF = $clog2(STRB_WIDTH);
    localparam int WORD_OFF = $clog2(INSTR_WIDTH / 8);
    localparam int SHIFT_W  = $clog2(DATA_WIDTH);

    arb_state_t              state_q;
    arb_owner_t              owner_q, last_grant_q, grant_d;
    logic                    gnt_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_aln_s;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q, dm_rdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                    if_ack_q, dm_ack_q, err_q;
    logic [INSTR_WIDTH-1:0]  if_rdata_q, if_word_s;
    logic [SHIFT_W-1:0]      if_shift_s;
    logic                    unused_addr_bits_s;

    riscv_arb_rr2 u_rr2 (
        .req_i        ({i_dm_req, i_if_req}),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid_d),
        .grant_o      (grant_d)
    );

    assign addr_aln_s = {addr_q[ADDR_WIDTH-1:BEAT_OFF], {BEAT_OFF{1'b0}}};
    // Bit offset of the addressed instruction word inside the returned beat
    assign if_shift_s = {addr_q[BEAT_OFF-1:WORD_OFF], {(WORD_OFF + 3){1'b0}}};
    assign if_word_s  = m_axil_rdata[if_shift_s +: INSTR_WIDTH];
    assign unused_addr_bits_s = ^addr_q[WORD_OFF-1:0];

    // Transaction FSM with all handshake and ack outputs registered
    always_ff @(posedge aclk) begin
        if (!anreset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid_d) begin
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= (grant_d == OWN_DM) ? i_dm_addr : i_if_addr;
                        we_q         <= (grant_d == OWN_DM) && i_dm_we;
                        wdata_q      <= i_dm_wdata;
                        wstrb_q      <= i_dm_wstrb;
                        if ((grant_d == OWN_DM) && i_dm_we) begin
                            state_q   <= WR_ADDR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axil_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axil_rvalid) begin
                        rready_q <= 1'b0;
                        err_q    <= resp_is_err(m_axil_rresp);
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= if_word_s;
                        end else begin
                            dm_rdata_q <= m_axil_rdata;
                        end
                        if_ack_q <= (owner_q == OWN_IF);
                        dm_ack_q <= (owner_q == OWN_DM);
                        state_q  <= ACK;
                    end
                end
                WR_ADDR: begin
                    // Address and data channels complete independently, in any order
                    if (m_axil_awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_axil_wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        bready_q <= 1'b0;
                        err_q    <= resp_is_err(m_axil_bresp);
                        if_ack_q <= 1'b0;
                        dm_ack_q <= 1'b1;
                        state_q  <= ACK;
                    end
                end
                ACK: begin
                    if_ack_q <= 1'b0;
                    dm_ack_q <= 1'b0;
                    err_q    <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    if_ack_q  <= 1'b0;
                    dm_ack_q  <= 1'b0;
                    err_q     <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_if_rdata     = if_rdata_q;
    assign o_if_ack       = if_ack_q;
    assign o_dm_rdata     = dm_rdata_q;
    assign o_dm_ack       = dm_ack_q;
    assign o_bus_err      = err_q;
    assign o_busy         = (state_q != IDLE);
    assign m_axil_awaddr  = addr_aln_s;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q && we_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_aln_s;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Bench for riscv_mem_port_arbiter: AXI-Lite slave with programmable stalls,
// byte-array reference memory and fairness model, directed steps then random rounds.
module tb_riscv_mem_port_arbiter;

    logic        aclk = 1'b0;
    logic        anreset;
    logic        i_if_req, i_dm_req, i_dm_we;
    logic [15:0] i_if_addr, i_dm_addr;
    logic [31:0] o_if_rdata;
    logic [63:0] i_dm_wdata, o_dm_rdata;
    logic [7:0]  i_dm_wstrb;
    logic        o_if_ack, o_dm_ack, o_bus_err, o_busy;
    logic [15:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;
    logic [63:0] m_axil_wdata, m_axil_rdata;
    logic [7:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp, m_axil_rresp;

    always #5 aclk = ~aclk;

    riscv_mem_port_arbiter dut (
        .aclk(aclk), .anreset(anreset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
        .i_dm_wstrb(i_dm_wstrb), .o_dm_rdata(o_dm_rdata), .o_dm_ack(o_dm_ack),
        .o_bus_err(o_bus_err), .o_busy(o_busy),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- AXI-Lite slave with per-channel wait counts ----------------
    int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
    logic [1:0]  resp_cfg;
    int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic        r_pend, aw_done, w_done, b_pend;
    logic [15:0] r_addr, aw_addr_l;
    logic [63:0] w_data_l;
    logic [7:0]  w_strb_l;
    logic [63:0] smem [0:255];
    logic        aw_hs, w_hs;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_strb;

    assign m_axil_arready = !r_pend && (ar_cnt >= ar_wait);
    assign m_axil_rvalid  = r_pend && (r_cnt >= r_wait);
    assign m_axil_rdata   = smem[r_addr[10:3]];
    assign m_axil_rresp   = resp_cfg;
    assign m_axil_awready = !aw_done && !b_pend && (aw_cnt >= aw_wait);
    assign m_axil_wready  = !w_done && !b_pend && (w_cnt >= w_wait);
    assign m_axil_bvalid  = b_pend && (b_cnt >= b_wait);
    assign m_axil_bresp   = resp_cfg;
    assign aw_hs   = m_axil_awvalid && m_axil_awready;
    assign w_hs    = m_axil_wvalid && m_axil_wready;
    assign wr_addr = aw_hs ? m_axil_awaddr : aw_addr_l;
    assign wr_data = w_hs ? m_axil_wdata : w_data_l;
    assign wr_strb = w_hs ? m_axil_wstrb : w_strb_l;

    always @(posedge aclk) begin
        if (!anreset) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0;
            r_addr <= 16'h0; aw_addr_l <= 16'h0; w_data_l <= 64'h0; w_strb_l <= 8'h0;
            for (int i = 0; i < 256; i++) smem[i] <= 64'h0;
        end else begin
            if (m_axil_arvalid && m_axil_arready) begin
                r_pend <= 1'b1; r_addr <= m_axil_araddr; r_cnt <= 0; ar_cnt <= 0;
            end else if (m_axil_arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (m_axil_rvalid && m_axil_rready) r_pend <= 1'b0;
            else if (r_pend && !m_axil_rvalid) r_cnt <= r_cnt + 1;
            if (aw_hs) begin
                aw_addr_l <= m_axil_awaddr; aw_cnt <= 0;
            end else if (m_axil_awvalid && !aw_done) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_data_l <= m_axil_wdata; w_strb_l <= m_axil_wstrb; w_cnt <= 0;
            end else if (m_axil_wvalid && !w_done) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                for (int b = 0; b < 8; b++)
                    if (wr_strb[b]) smem[wr_addr[10:3]][b*8 +: 8] <= wr_data[b*8 +: 8];
                aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end else begin
                aw_done <= aw_done || aw_hs; w_done <= w_done || w_hs;
            end
            if (m_axil_bvalid && m_axil_bready) b_pend <= 1'b0;
            else if (b_pend && !m_axil_bvalid) b_cnt <= b_cnt + 1;
        end
    end

    // ---------------- AXI rule: a valid never drops before its ready ----------------
    logic ar_pend_q = 1'b0, aw_pend_q = 1'b0, w_pend_q = 1'b0;
    always @(negedge aclk) begin
        if (anreset && ar_pend_q) chk("arvalid_hold", 64'(m_axil_arvalid), 64'd1);
        if (anreset && aw_pend_q) chk("awvalid_hold", 64'(m_axil_awvalid), 64'd1);
        if (anreset && w_pend_q)  chk("wvalid_hold", 64'(m_axil_wvalid), 64'd1);
        ar_pend_q <= anreset && m_axil_arvalid && !m_axil_arready;
        aw_pend_q <= anreset && m_axil_awvalid && !m_axil_awready;
        w_pend_q  <= anreset && m_axil_wvalid && !m_axil_wready;
    end

    // ---------------- Reference model: byte memory + fairness ----------------
    logic [7:0] ref_mem [0:2047];
    logic       last_own;   // 0 = IF served last, 1 = DM served last

    function automatic logic [63:0] ref_rd64(input logic [15:0] a);
        logic [63:0] r;
        int base;
        base = int'(a[10:3]) * 8;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = ref_mem[base + k];
        return r;
    endfunction

    task automatic ref_wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
        int base;
        base = int'(a[10:3]) * 8;
        for (int k = 0; k < 8; k++) if (s[k]) ref_mem[base + k] = d[k*8 +: 8];
    endtask

    task automatic do_reset();
        anreset = 1'b0; i_if_req = 1'b0; i_dm_req = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        anreset = 1'b1;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        last_own = 1'b0;
    endtask

    // One round: optionally both ports request in the same cycle; every ack is checked.
    task automatic do_round(input logic if_en, input logic dm_en, input logic we,
                            input logic [15:0] ia, input logic [15:0] da,
                            input logic [63:0] wd, input logic [7:0] ws,
                            output int gap, output logic first_dm, output logic [63:0] dm_obs);
        int pending, t, c0;
        logic exp_dm;
        logic [63:0] ref_w;
        @(negedge aclk);
        i_if_req = if_en; i_if_addr = ia;
        i_dm_req = dm_en; i_dm_we = we; i_dm_addr = da; i_dm_wdata = wd; i_dm_wstrb = ws;
        pending = int'(if_en) + int'(dm_en);
        exp_dm = dm_en && (!if_en || last_own == 1'b0);
        first_dm = exp_dm; gap = 0; c0 = 0; dm_obs = 64'h0; t = 0;
        while (pending > 0 && t < 200) begin
            @(posedge aclk); #1; t++;
            if (o_if_ack || o_dm_ack) begin
                chk("ack_owner", 64'({o_if_ack, o_dm_ack}), exp_dm ? 64'd1 : 64'd2);
                chk("bus_err", 64'(o_bus_err), 64'(resp_cfg != 2'b00));
                if (exp_dm) begin
                    if (we) ref_wr(da, wd, ws);
                    else begin
                        ref_w = ref_rd64(da);
                        dm_obs = o_dm_rdata;
                        chk("dm_rdata", o_dm_rdata, ref_w);
                    end
                    i_dm_req = 1'b0;
                end else begin
                    ref_w = ref_rd64(ia);
                    chk("if_rdata", 64'(o_if_rdata), ia[2] ? 64'(ref_w[63:32]) : 64'(ref_w[31:0]));
                    i_if_req = 1'b0;
                end
                last_own = exp_dm;
                if (pending == 2) c0 = cyc;
                else if (if_en && dm_en) gap = cyc - c0;
                pending--;
                exp_dm = !exp_dm;
            end
        end
        chk("round_timeout", 64'(pending), 64'd0);
        @(posedge aclk); #1;
        chk("idle_after_round", 64'(o_busy), 64'd0);
    endtask

    initial begin
        int gap, t;
        logic fdm;
        logic [63:0] dmo;
        int mode;
        logic [15:0] ia, da;
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0; resp_cfg = 2'b00;
        i_if_addr = 16'h0; i_dm_we = 1'b0; i_dm_addr = 16'h0; i_dm_wdata = 64'h0; i_dm_wstrb = 8'h0;

        // Reset state
        do_reset();
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_if_ack", 64'(o_if_ack), 64'd0);
        chk("rst_dm_ack", 64'(o_dm_ack), 64'd0);
        chk("rst_err", 64'(o_bus_err), 64'd0);
        chk("rst_valids", 64'({m_axil_arvalid, m_axil_awvalid, m_axil_wvalid}), 64'd0);
        chk("rst_readies", 64'({m_axil_rready, m_axil_bready}), 64'd0);
        chk("rst_if_rdata", 64'(o_if_rdata), 64'd0);
        chk("rst_dm_rdata", o_dm_rdata, 64'd0);

        // Minimum-latency IF fetch of the upper word of beat 0x0008
        do_round(1'b0, 1'b1, 1'b1, 16'h0, 16'h0008, 64'hAAAA_BBBB_1111_2222, 8'hFF, gap, fdm, dmo);
        @(negedge aclk);
        i_if_req = 1'b1; i_if_addr = 16'h000C;
        @(posedge aclk); #1;
        chk("t1_arvalid", 64'(m_axil_arvalid), 64'd1);
        chk("t1_araddr", 64'(m_axil_araddr), 64'h0008);
        chk("t1_busy", 64'(o_busy), 64'd1);
        @(posedge aclk); #1;
        chk("t1_rready", 64'(m_axil_rready), 64'd1);
        chk("t1_no_early_ack", 64'(o_if_ack), 64'd0);
        @(posedge aclk); #1;
        chk("t1_if_ack", 64'({o_if_ack, o_dm_ack}), 64'd2);
        chk("t1_if_rdata", 64'(o_if_rdata), 64'hAAAA_BBBB);
        chk("t1_err", 64'(o_bus_err), 64'd0);
        i_if_req = 1'b0; last_own = 1'b0;
        @(posedge aclk); #1;
        chk("t1_ack_one_cycle", 64'(o_if_ack), 64'd0);
        chk("t1_idle", 64'(o_busy), 64'd0);

        // Simultaneous requests after reset: DM first, IF 4 cycles later, every time
        do_reset();
        for (int r = 0; r < 3; r++) begin
            do_round(1'b1, 1'b1, 1'b0, 16'h000C, 16'h0008, 64'h0, 8'h0, gap, fdm, dmo);
            chk("t2_dm_first", 64'(fdm), 64'd1);
            chk("t2_gap", 64'(gap), 64'd4);
        end

        // DM write with awready delayed three cycles and wready immediate
        aw_wait = 3;
        @(negedge aclk);
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 16'h0010;
        i_dm_wdata = 64'h0123_4567_89AB_CDEF; i_dm_wstrb = 8'h0F;
        @(posedge aclk); #1;
        chk("t3_aw_w_raised", 64'({m_axil_awvalid, m_axil_wvalid}), 64'd3);
        chk("t3_awaddr", 64'(m_axil_awaddr), 64'h0010);
        chk("t3_wstrb", 64'(m_axil_wstrb), 64'h0F);
        for (int k = 0; k < 2; k++) begin
            @(posedge aclk); #1;
            chk("t3_w_drop_aw_held", 64'({m_axil_awvalid, m_axil_wvalid}), 64'd2);
        end
        t = 0;
        while (!o_dm_ack && t < 30) begin
            @(posedge aclk); #1; t++;
        end
        chk("t3_write_ack", 64'({o_if_ack, o_dm_ack}), 64'd1);
        chk("t3_err", 64'(o_bus_err), 64'd0);
        i_dm_req = 1'b0; last_own = 1'b1;
        ref_wr(16'h0010, 64'h0123_4567_89AB_CDEF, 8'h0F);
        @(posedge aclk); #1;
        aw_wait = 0;
        do_round(1'b0, 1'b1, 1'b0, 16'h0, 16'h0010, 64'h0, 8'h0, gap, fdm, dmo);
        chk("t3_readback", dmo, 64'h0000_0000_89AB_CDEF);

        // Error response on an IF read, then a clean one
        resp_cfg = 2'b10;
        do_round(1'b1, 1'b0, 1'b0, 16'h0014, 16'h0, 64'h0, 8'h0, gap, fdm, dmo);
        resp_cfg = 2'b00;
        do_round(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 64'h0, 8'h0, gap, fdm, dmo);

        // Reset while waiting for read data abandons the transaction
        r_wait = 5;
        @(negedge aclk);
        i_if_req = 1'b1; i_if_addr = 16'h0004;
        @(posedge aclk); #1;
        chk("t5_arvalid", 64'(m_axil_arvalid), 64'd1);
        @(posedge aclk); #1;
        chk("t5_in_rd_data", 64'({m_axil_arvalid, m_axil_rready}), 64'd1);
        anreset = 1'b0; i_if_req = 1'b0;
        @(posedge aclk); #1;
        chk("t5_rst_handshake", 64'({m_axil_arvalid, m_axil_rready}), 64'd0);
        chk("t5_rst_acks", 64'({o_if_ack, o_dm_ack}), 64'd0);
        chk("t5_rst_busy", 64'(o_busy), 64'd0);
        r_wait = 0;
        do_reset();
        do_round(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0, 64'h0, 8'h0, gap, fdm, dmo);

        // Random mixed traffic with random channel stalls
        for (int r = 0; r < 1000; r++) begin
            ar_wait = $urandom_range(0, 5); r_wait = $urandom_range(0, 5);
            aw_wait = $urandom_range(0, 5); w_wait = $urandom_range(0, 5);
            b_wait = $urandom_range(0, 5);
            resp_cfg = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
            mode = $urandom_range(1, 3);
            ia = 16'($urandom_range(0, 16'h7FF));
            da = 16'($urandom_range(0, 16'h7FF));
            do_round(mode[0], mode[1], 1'($urandom_range(0, 1)), ia, da,
                     {$urandom, $urandom}, 8'($urandom_range(0, 255)), gap, fdm, dmo);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
